// File: rtl/alu_seq_ctrl_if.sv
// Command/result bundle between decode, the ALU sequencer and the ALU datapath.
interface alu_seq_ctrl_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic                 flush;
   logic [4:0]           reg_en;
   logic                 f_add;
   logic                 f_load;
   logic [BUS_WIDTH-1:0] alu_result;
   logic                 res_valid;
   logic                 res_ready;
   logic [BUS_WIDTH-1:0] res_data;
   logic                 busy;

   modport master (
      output cmd_valid, cmd_op, flush, alu_result, res_ready,
      input  cmd_ready, reg_en, f_add, f_load, res_valid, res_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, flush, alu_result, res_ready,
      output cmd_ready, reg_en, f_add, f_load, res_valid, res_data, busy
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ALU control sequencer: walks register stages A/B, C/D, E, settles, captures the result.
// Optional ALU_SEQ_PERF_EN adds a 16-bit completed-result counter port op_count.
module alu_seq_ctrl #(
   parameter int BUS_WIDTH = 8,
   parameter int WAIT_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst,
`ifdef ALU_SEQ_PERF_EN
   output logic [15:0] op_count,
`endif
   alu_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      S_AB,
      S_CD,
      S_E,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ADDI = 2'b10;
   localparam logic [1:0] OP_MAC  = 2'b11;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC - 1);

   state_t               state_reg;
   logic [1:0]           op_q;
   logic [3:0]           wait_cnt_reg;
   logic                 f_add_reg;
   logic                 f_load_reg;
   logic [BUS_WIDTH-1:0] res_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         op_q         <= OP_NOP;
         wait_cnt_reg <= 4'd0;
         f_add_reg    <= 1'b0;
         f_load_reg   <= 1'b0;
         res_data_reg <= '0;
      end else if (bus.flush) begin
         // Abort wins over everything; the last captured result is kept.
         state_reg  <= IDLE;
         f_add_reg  <= 1'b0;
         f_load_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.cmd_valid) begin
                  op_q       <= bus.cmd_op;
                  f_add_reg  <= (bus.cmd_op == OP_ADDI);
                  f_load_reg <= (bus.cmd_op == OP_LOAD);
                  case (bus.cmd_op)
                     OP_MAC, OP_ADDI: state_reg <= S_AB;
                     OP_LOAD:         state_reg <= S_E;
                     default:         state_reg <= S_DONE;
                  endcase
               end
            end
            S_AB: state_reg <= S_CD;
            S_CD: state_reg <= S_E;
            S_E: begin
               state_reg    <= S_WAIT;
               wait_cnt_reg <= WAIT_INIT;
            end
            S_WAIT: begin
               if (wait_cnt_reg == 4'd0) begin
                  state_reg <= S_DONE;
                  if (op_q != OP_NOP) begin
                     res_data_reg <= bus.alu_result;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 4'd1;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  state_reg  <= IDLE;
                  f_add_reg  <= 1'b0;
                  f_load_reg <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.reg_en = 5'b00000;
      case (state_reg)
         S_AB:    bus.reg_en = 5'b00011;
         S_CD:    bus.reg_en = 5'b01100;
         S_E:     bus.reg_en = 5'b10000;
         default: bus.reg_en = 5'b00000;
      endcase
   end

   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.res_valid = (state_reg == S_DONE);
   assign bus.f_add     = f_add_reg;
   assign bus.f_load    = f_load_reg;
   assign bus.res_data  = res_data_reg;

`ifdef ALU_SEQ_PERF_EN
   logic [15:0] op_count_reg;

   // Counts result handshakes; survives flush, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_reg <= 16'd0;
      end else if (bus.res_valid && bus.res_ready) begin
         op_count_reg <= op_count_reg + 16'd1;
      end
   end

   assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (WAIT_CYC=1 and 3) share command stimulus.
module tb_alu_seq_ctrl;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ADDI = 2'b10;
   localparam logic [1:0] OP_MAC  = 2'b11;
   localparam logic [9:0] IDLE_CTRL = 10'b0100000000;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] q1[$];
   logic [7:0] q3[$];
   logic [7:0] prev[2];

   alu_seq_ctrl_if #(.BUS_WIDTH(8)) if1 ();
   alu_seq_ctrl_if #(.BUS_WIDTH(8)) if3 ();

`ifdef ALU_SEQ_PERF_EN
   logic [15:0] oc1;
   logic [15:0] oc3;
   int          exp_ops = 0;
`endif

   alu_seq_ctrl #(.BUS_WIDTH(8), .WAIT_CYC(1)) dut1 (
      .clk(clk),
      .rst(rst),
`ifdef ALU_SEQ_PERF_EN
      .op_count(oc1),
`endif
      .bus(if1)
   );

   alu_seq_ctrl #(.BUS_WIDTH(8), .WAIT_CYC(3)) dut3 (
      .clk(clk),
      .rst(rst),
`ifdef ALU_SEQ_PERF_EN
      .op_count(oc3),
`endif
      .bus(if3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int d, input int c,
                      input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut_w%0d cycle %0d: got %h expected %h",
                  name, (d == 0) ? 1 : 3, c, act, exp);
      end
   endtask

   function automatic logic [9:0] ctrl_of(input int d);
      if (d == 0)
         return {if1.busy, if1.cmd_ready, if1.res_valid, if1.f_add, if1.f_load, if1.reg_en};
      return {if3.busy, if3.cmd_ready, if3.res_valid, if3.f_add, if3.f_load, if3.reg_en};
   endfunction

   function automatic logic [7:0] data_of(input int d);
      return (d == 0) ? if1.res_data : if3.res_data;
   endfunction

   function automatic int done_start(input logic [1:0] op, input int w);
      if (op == OP_NOP)  return 1;
      if (op == OP_LOAD) return 2 + w;
      return 4 + w;
   endfunction

   function automatic logic [4:0] exp_regen(input logic [1:0] op, input int c);
      if (op == OP_MAC || op == OP_ADDI) begin
         if (c == 1) return 5'b00011;
         if (c == 2) return 5'b01100;
         if (c == 3) return 5'b10000;
      end else if (op == OP_LOAD && c == 1) begin
         return 5'b10000;
      end
      return 5'b00000;
   endfunction

   task automatic drive_cmd(input logic v, input logic [1:0] op);
      if1.cmd_valid = v; if3.cmd_valid = v;
      if1.cmd_op = op;   if3.cmd_op = op;
   endtask

   task automatic drive_flush(input logic f);
      if1.flush = f; if3.flush = f;
   endtask

   task automatic drive_rr(input logic r);
      if1.res_ready = r; if3.res_ready = r;
   endtask

   task automatic drive_alu(input int d, input logic [7:0] val);
      if (d == 0) if1.alu_result = val;
      else        if3.alu_result = val;
   endtask

   task automatic push_exp(input int d, input logic [7:0] val);
      if (d == 0) q1.push_back(val);
      else        q3.push_back(val);
   endtask

   // Scoreboard monitor: every result handshake pops one expected value.
   always @(negedge clk) begin
      if (!rst && if1.res_valid && if1.res_ready) begin
         $display("result dut_w1 data=%h", if1.res_data);
         if (q1.size() == 0) chk("unexpected_result", 0, 0, 16'(if1.res_data), 16'hFFFF);
         else                chk("result_data", 0, 0, 16'(if1.res_data), 16'(q1.pop_front()));
      end
      if (!rst && if3.res_valid && if3.res_ready) begin
         $display("result dut_w3 data=%h", if3.res_data);
         if (q3.size() == 0) chk("unexpected_result", 1, 0, 16'(if3.res_data), 16'hFFFF);
         else                chk("result_data", 1, 0, 16'(if3.res_data), 16'(q3.pop_front()));
      end
   end

   // One command, 14 observed cycles; expectations come from the cycle-timing table.
   task automatic run_cmd(input string name, input logic [1:0] op,
                          input logic [7:0] v0, input logic [7:0] v1,
                          input int release_c, input int flush_c);
      logic [7:0] newv[2];
      int         w, ds, lv;
      logic       alive, bsy, cap;
      logic [9:0] exp_ctrl;
      logic [7:0] exp_data;
      newv[0] = v0;
      newv[1] = v1;
      $display("cmd %s op=%0d release=%0d flush=%0d", name, op, release_c, flush_c);
      if (flush_c == 0) begin
         for (int d = 0; d < 2; d++) push_exp(d, (op == OP_NOP) ? prev[d] : newv[d]);
`ifdef ALU_SEQ_PERF_EN
         exp_ops++;
`endif
      end
      drive_cmd(1'b1, op);
      drive_rr(release_c <= 0);
      drive_flush(1'b0);
      drive_alu(0, ~v0);
      drive_alu(1, ~v1);
      @(posedge clk); #1;
      drive_cmd(1'b0, OP_NOP);
      for (int c = 1; c <= 14; c++) begin
         drive_rr(c >= release_c);
         drive_flush(c == flush_c);
         for (int d = 0; d < 2; d++) begin
            w  = (d == 0) ? 1 : 3;
            ds = done_start(op, w);
            drive_alu(d, (c == ds - 1) ? newv[d] : ~newv[d]);
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            w     = (d == 0) ? 1 : 3;
            ds    = done_start(op, w);
            lv    = (release_c > ds) ? release_c : ds;
            alive = (flush_c == 0) || (c <= flush_c);
            bsy   = alive && (c <= lv);
            cap   = (op != OP_NOP) && ((flush_c == 0) || (flush_c >= ds));
            exp_ctrl = {bsy, !bsy, bsy && (c >= ds), bsy && (op == OP_ADDI),
                        bsy && (op == OP_LOAD), alive ? exp_regen(op, c) : 5'b00000};
            exp_data = (cap && c >= ds) ? newv[d] : prev[d];
            chk({name, "_ctrl"}, d, c, 16'(ctrl_of(d)), 16'(exp_ctrl));
            chk({name, "_data"}, d, c, 16'(data_of(d)), 16'(exp_data));
         end
         @(posedge clk); #1;
      end
      drive_flush(1'b0);
      drive_rr(1'b1);
      for (int d = 0; d < 2; d++) begin
         ds = done_start(op, (d == 0) ? 1 : 3);
         if (op != OP_NOP && (flush_c == 0 || flush_c >= ds)) prev[d] = newv[d];
      end
   endtask

   initial begin
      logic [9:0] exp_b2b;
      rst = 1'b1;
      drive_cmd(1'b0, OP_NOP);
      drive_flush(1'b0);
      drive_rr(1'b0);
      drive_alu(0, 8'h00);
      drive_alu(1, 8'h00);
      prev[0] = 8'h00;
      prev[1] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset_ctrl", d, 0, 16'(ctrl_of(d)), 16'(IDLE_CTRL));
         chk("reset_data", d, 0, 16'(data_of(d)), 16'h0000);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("post_reset_ctrl", d, 0, 16'(ctrl_of(d)), 16'(IDLE_CTRL));
      @(posedge clk); #1;

      run_cmd("mac", OP_MAC, 8'h5A, 8'h5A, 0, 0);
      run_cmd("load", OP_LOAD, 8'h81, 8'h81, 0, 0);
      run_cmd("addi_stall", OP_ADDI, 8'h3C, 8'h3C, 11, 0);
      run_cmd("mac_flush", OP_MAC, 8'hEE, 8'hEE, 0, 2);
      run_cmd("nop", OP_NOP, 8'h00, 8'h00, 0, 0);

      // Back-to-back NOPs: accept again in the cycle after the handshake.
      $display("cmd back_to_back_nop x2");
      for (int d = 0; d < 2; d++) begin
         push_exp(d, prev[d]);
         push_exp(d, prev[d]);
      end
`ifdef ALU_SEQ_PERF_EN
      exp_ops += 2;
`endif
      drive_rr(1'b1);
      drive_cmd(1'b1, OP_NOP);
      @(posedge clk); #1;
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) drive_cmd(1'b0, OP_NOP);
         @(negedge clk);
         exp_b2b = (c % 2 == 1) ? 10'b1010000000 : IDLE_CTRL;
         for (int d = 0; d < 2; d++) chk("b2b_ctrl", d, c, 16'(ctrl_of(d)), 16'(exp_b2b));
         @(posedge clk); #1;
      end

      // Flush in IDLE drops a pending command.
      $display("cmd flush_in_idle op=%0d", OP_MAC);
      drive_cmd(1'b1, OP_MAC);
      drive_flush(1'b1);
      @(posedge clk); #1;
      drive_cmd(1'b0, OP_NOP);
      drive_flush(1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("flush_idle_ctrl", d, 1, 16'(ctrl_of(d)), 16'(IDLE_CTRL));
      @(posedge clk); #1;

      // Asynchronous reset in S_WAIT, checked before any further clock edge.
      $display("cmd mac_async_reset op=%0d", OP_MAC);
      drive_cmd(1'b1, OP_MAC);
      drive_alu(0, 8'hA5);
      drive_alu(1, 8'hA5);
      @(posedge clk); #1;
      drive_cmd(1'b0, OP_NOP);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("async_reset_ctrl", d, 4, 16'(ctrl_of(d)), 16'(IDLE_CTRL));
         chk("async_reset_data", d, 4, 16'(data_of(d)), 16'h0000);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      prev[0] = 8'h00;
      prev[1] = 8'h00;
`ifdef ALU_SEQ_PERF_EN
      exp_ops = 0;
`endif
      @(posedge clk); #1;

      run_cmd("addi_after_reset", OP_ADDI, 8'h77, 8'h99, 0, 0);
      run_cmd("load2", OP_LOAD, 8'h10, 8'h20, 0, 0);
      run_cmd("mac2", OP_MAC, 8'hC3, 8'h3C, 0, 0);
      run_cmd("nop2", OP_NOP, 8'h00, 8'h00, 0, 0);

`ifdef ALU_SEQ_PERF_EN
      chk("op_count", 0, 0, oc1, 16'(exp_ops));
      chk("op_count", 1, 0, oc3, 16'(exp_ops));
      chk("op_count_four", 0, 0, oc1, 16'd4);
      dut1.op_count_reg = 16'hFFFF;
      dut3.op_count_reg = 16'hFFFF;
      run_cmd("nop_wrap", OP_NOP, 8'h00, 8'h00, 0, 0);
      chk("op_count_wrap", 0, 0, oc1, 16'h0000);
      chk("op_count_wrap", 1, 0, oc3, 16'h0000);
`endif

      chk("queue_empty", 0, 0, 16'(q1.size()), 16'd0);
      chk("queue_empty", 1, 0, 16'(q3.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer that drives the control inputs of the 8-bit ALU datapath: register enables `reg_en[4:0]`, operand-select strobes `f_add` and `f_load`, and result capture. It accepts one command at a time over a valid/ready handshake and walks the ALU input-register stages in a fixed order. After a programmable settle time it captures `alu_result` and presents it on a valid/ready result port. It sits between the instruction decode stage and the ALU.

## Interface
- `BUS_WIDTH`, 8, width of `alu_result` and `res_data`
- `WAIT_CYC`, 1, settle cycles after the last register write before capture; legal range 1..15
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  2  operation code: 00 NOP, 01 LOAD, 10 ADDI, 11 MAC
- `flush`  in  1  synchronous abort to IDLE
- `reg_en`  out  5  ALU register enables; [0] A, [1] B, [2] C, [3] D, [4] E
- `f_add`  out  1  immediate/add path select
- `f_load`  out  1  switch-load path select
- `alu_result`  in  BUS_WIDTH  ALU combinational result
- `res_valid`  out  1  `res_data` holds a completed result
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  BUS_WIDTH  captured result
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, S_AB, S_CD, S_E, S_WAIT, S_DONE.
- `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid && cmd_ready`. The op is latched into `op_q`.
- Transitions from IDLE on accept:
  - MAC and ADDI go to S_AB.
  - LOAD goes to S_E.
  - NOP goes to S_DONE.
- Fixed transitions: S_AB -> S_CD -> S_E -> S_WAIT.
- S_WAIT loads a 4-bit counter with `WAIT_CYC-1` on entry.
  - It decrements each cycle.
  - When the counter is 0, the state goes to S_DONE and `res_data <= alu_result` on the same edge.
- S_DONE: `res_valid`=1. It exits to IDLE on `res_ready`. `res_data` is stable while `res_valid` is high.
- NOP: `res_data` is unchanged. `res_valid` still pulses through S_DONE.
- Register enables are decoded combinationally from the state:
  - S_AB asserts `reg_en[1:0]`=11.
  - S_CD asserts `reg_en[3:2]`=11.
  - S_E asserts `reg_en[4]`.
  - All other states give `reg_en`=0.
- `f_add`/`f_load` are registered on accept and held constant until return to IDLE; they are 0 in IDLE:
  - LOAD: f_load=1, f_add=0.
  - ADDI: f_add=1, f_load=0.
  - MAC and NOP: both 0.
- `flush` has priority over every transition except reset.
  - Next state is IDLE and `f_add`/`f_load` are cleared.
  - `res_data` keeps its value.
  - A `flush` in IDLE with `cmd_valid` high drops the command; no accept occurs.
- Reset mid-operation: immediate return to IDLE with all registers at their reset values. No partial enables are issued after reset deasserts.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1, `busy`=0
  - `reg_en`=0, `f_add`=0, `f_load`=0
  - `res_valid`=0, `res_data`=0
- The accept edge is cycle 0.
- MAC/ADDI: `reg_en[1:0]` in cycle 1, `reg_en[3:2]` in cycle 2, `reg_en[4]` in cycle 3, `res_valid` from cycle 4+WAIT_CYC.
- LOAD: `reg_en[4]` in cycle 1, `res_valid` from cycle 2+WAIT_CYC.
- NOP: `res_valid` in cycle 1.
- `alu_result` is sampled on the final S_WAIT edge, WAIT_CYC cycles after the S_E edge.
- Back-to-back throughput: a new command can be accepted in the cycle after the `res_ready` handshake, with no bubble beyond IDLE.
- `res_ready` held high before `res_valid` gives a single-cycle S_DONE.

## Configuration
- `ALU_SEQ_PERF_EN` defined:
  - Adds output `op_count[15:0]`.
  - It increments on every result handshake (`res_valid && res_ready`), including NOP.
  - It wraps 0xFFFF -> 0 and resets to 0.
  - It is not cleared by `flush`.
- `ALU_SEQ_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, MAC accepted with WAIT_CYC=1 and `alu_result`=8'h5A driven from cycle 3 -> `reg_en` = 03, 0C, 10 in cycles 1-3; `res_valid`=1 in cycle 5; `res_data`=8'h5A; `f_add`=`f_load`=0 throughout.
- LOAD with WAIT_CYC=3 and `alu_result`=8'h81 -> `f_load`=1 from cycle 1; only `reg_en[4]` pulses, in cycle 1; `res_valid` in cycle 5; `res_data`=8'h81.
- ADDI with `res_ready` held low 4 cycles after `res_valid` -> `res_valid`/`res_data` stable 5 cycles; `cmd_ready`=0 until the handshake; `f_add`=1 until IDLE.
- `flush` asserted in S_CD of a MAC -> IDLE next cycle; `reg_en[4]` never asserts; `res_valid` stays 0; previous `res_data` retained.
- `rst` asserted asynchronously mid S_WAIT -> all outputs at reset values without waiting for a clock edge; the next command runs normally.
- With `ALU_SEQ_PERF_EN`: 3 ops plus 1 NOP completed -> `op_count`=4; preload `op_count` to 16'hFFFF, complete one op -> `op_count`=0.
